// File: rtl/rx_block_lock_descrambler_32b.sv
// 10GBASE-R receive block lock (clause 49) and x^58+x^39+1 self-synchronous descrambler,
// 32 bits per beat, feeding decoder_rx_32b.
module rx_block_lock_descrambler_32b #(
    parameter int unsigned SH_CNT_MAX     = 64,
    parameter int unsigned SH_INVALID_MAX = 16,
    parameter int unsigned SLIP_WAIT      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  hdr_in,
    input  logic [31:0] data_in,
    input  logic        data_in_en,
    input  logic        half_in,
    output logic        slip,
    output logic        block_lock,
    output logic [31:0] dout,
    output logic [1:0]  ctrlout,
    output logic        dout_en,
    output logic        even
);

    localparam logic [2:0] LOCK_INIT    = 3'd0;
    localparam logic [2:0] RESET_CNT    = 3'd1;
    localparam logic [2:0] TEST_SH      = 3'd2;
    localparam logic [2:0] SLIP         = 3'd3;
    localparam logic [2:0] SLIP_WAIT_ST = 3'd4;

    logic [2:0]  state;
    logic [6:0]  sh_cnt;
    logic [4:0]  sh_invalid_cnt;
    logic [3:0]  wait_cnt;
    logic [57:0] descr_st;
    logic        first_fwd;

    logic        sh_test;
    logic        sh_bad;
    logic [6:0]  sh_cnt_next;
    logic [4:0]  sh_invalid_next;
    logic [89:0] descr_hist;
    logic [31:0] descr_out;

    always_comb begin
        sh_test = data_in_en && !half_in && (state == TEST_SH);
        sh_bad  = (hdr_in[0] == hdr_in[1]);
        sh_cnt_next = (sh_cnt == 7'(SH_CNT_MAX)) ? sh_cnt : sh_cnt + 7'd1;
        sh_invalid_next = sh_invalid_cnt;
        if (sh_bad && sh_invalid_cnt != 5'(SH_INVALID_MAX))
            sh_invalid_next = sh_invalid_cnt + 5'd1;
    end

    // History is kept oldest-first, so the 39- and 58-bit taps of bit i land on
    // fixed 32-bit slices of {data_in, descr_st} and the whole word unrolls at once.
    always_comb begin
        descr_hist = {data_in, descr_st};
        descr_out  = data_in ^ descr_hist[50:19] ^ descr_hist[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= LOCK_INIT;
            sh_cnt         <= '0;
            sh_invalid_cnt <= '0;
            wait_cnt       <= '0;
            slip           <= 1'b0;
            block_lock     <= 1'b0;
        end else begin
            slip <= 1'b0;
            case (state)
                LOCK_INIT: begin
                    block_lock <= 1'b0;
                    state      <= RESET_CNT;
                end
                RESET_CNT: begin
                    sh_cnt         <= '0;
                    sh_invalid_cnt <= '0;
                    state          <= TEST_SH;
                end
                TEST_SH: begin
                    if (sh_test) begin
                        sh_cnt         <= sh_cnt_next;
                        sh_invalid_cnt <= sh_invalid_next;
                        if (!block_lock) begin
                            if (sh_bad) begin
                                state <= SLIP;
                            end else if (sh_cnt_next == 7'(SH_CNT_MAX)) begin
                                block_lock <= 1'b1;
                                state      <= RESET_CNT;
                            end
                        end else begin
                            // Loss of lock is checked first so it wins on the window's last header.
                            if (sh_invalid_next == 5'(SH_INVALID_MAX)) begin
                                block_lock <= 1'b0;
                                state      <= SLIP;
                            end else if (sh_cnt_next == 7'(SH_CNT_MAX)) begin
                                state <= RESET_CNT;
                            end
                        end
                    end
                end
                SLIP: begin
                    slip       <= 1'b1;
                    block_lock <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= SLIP_WAIT_ST;
                end
                SLIP_WAIT_ST: begin
                    if (data_in_en) begin
                        if (wait_cnt != 4'(SLIP_WAIT))
                            wait_cnt <= wait_cnt + 4'd1;
                        else if (!half_in)
                            state <= RESET_CNT;
                    end
                end
                default: state <= LOCK_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout      <= '0;
            ctrlout   <= '0;
            dout_en   <= 1'b0;
            even      <= 1'b0;
            descr_st  <= '0;
            first_fwd <= 1'b0;
        end else begin
            dout_en <= 1'b0;
            if (data_in_en) begin
                dout     <= descr_out;
                even     <= half_in;
                descr_st <= descr_hist[89:32];
                if (!half_in) begin
                    ctrlout   <= hdr_in;
                    first_fwd <= block_lock;
                    dout_en   <= block_lock;
                end else begin
                    // A second half is forwarded only if its own first half was.
                    first_fwd <= 1'b0;
                    dout_en   <= block_lock && first_fwd;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_block_lock_descrambler_32b.sv
// Self-checking bench for rx_block_lock_descrambler_32b: lock acquisition, slips,
// locked tolerance/loss, descrambling against a bench scrambler, and mid-run resets.
module tb_rx_block_lock_descrambler_32b;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  hdr_in;
    logic [31:0] data_in;
    logic        data_in_en;
    logic        half_in;
    logic        slip;
    logic        block_lock;
    logic [31:0] dout;
    logic [1:0]  ctrlout;
    logic        dout_en;
    logic        even;

    always #5 clk = ~clk;

    rx_block_lock_descrambler_32b #(
        .SH_CNT_MAX(64),
        .SH_INVALID_MAX(16),
        .SLIP_WAIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hdr_in(hdr_in),
        .data_in(data_in),
        .data_in_en(data_in_en),
        .half_in(half_in),
        .slip(slip),
        .block_lock(block_lock),
        .dout(dout),
        .ctrlout(ctrlout),
        .dout_en(dout_en),
        .even(even)
    );

    typedef struct {
        logic [1:0]  hdr;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        exp_lock;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  c;
        logic        ev;
        logic        den;
        logic        chk_d;
        logic        chk_ce;
        logic        lk;
        logic        sl;
    } exp_t;

    vec_t        tbl [8];
    exp_t        sb [$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned nbeats = 0;
    logic [57:0] tx_s;
    logic        cur_lock = 1'b0;
    logic [1:0]  ctrl_model = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Bench scrambler: sc[i] = d[i] ^ s[38] ^ s[57], s shifts in scrambled bits (s[0] newest).
    function automatic logic [31:0] scramble(input logic [31:0] d);
        logic [31:0] sc;
        for (int i = 0; i < 32; i++) begin
            sc[i] = d[i] ^ tx_s[38] ^ tx_s[57];
            tx_s  = {tx_s[56:0], sc[i]};
        end
        return sc;
    endfunction

    task automatic beat(input logic en, input logic half, input logic [1:0] hdr,
                        input logic [31:0] payload, input logic lk, input logic sl,
                        input logic den);
        exp_t e;
        exp_t g;
        data_in_en = en;
        half_in    = half;
        hdr_in     = hdr;
        data_in    = en ? scramble(payload) : $urandom;
        if (en && !half) ctrl_model = hdr;
        e.d = payload; e.c = ctrl_model; e.ev = half; e.den = den;
        e.chk_d = en && (nbeats >= 2); e.chk_ce = en; e.lk = lk; e.sl = sl;
        sb.push_back(e);
        if (en) nbeats++;
        @(posedge clk);
        #1;
        g = sb.pop_front();
        if (g.chk_d)  chk("dout", 64'(dout), 64'(g.d));
        if (g.chk_ce) begin
            chk("ctrlout", 64'(ctrlout), 64'(g.c));
            chk("even", 64'(even), 64'(g.ev));
        end
        chk("dout_en", 64'(dout_en), 64'(g.den));
        chk("block_lock", 64'(block_lock), 64'(g.lk));
        chk("slip", 64'(slip), 64'(g.sl));
    endtask

    // One 66-bit block: header beat then second half (header lines driven to 00 to show they are ignored).
    task automatic blk(input logic [1:0] hdr, input logic [31:0] lo, input logic [31:0] hi,
                       input logic lk, input logic sl);
        logic den0;
        den0 = cur_lock;
        beat(1'b1, 1'b0, hdr, lo, lk, 1'b0, den0);
        beat(1'b1, 1'b1, 2'b00, hi, lk, sl, lk & den0);
        cur_lock = lk;
    endtask

    task automatic blk_r(input logic [1:0] hdr, input logic lk, input logic sl);
        blk(hdr, $urandom, $urandom, lk, sl);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            beat(1'b0, 1'b0, 2'b01, 32'h0, cur_lock, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        data_in_en = 1'b1;
        half_in    = 1'b1;
        hdr_in     = 2'b10;
        data_in    = $urandom;
        @(posedge clk);
        #1;
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_ctrlout", 64'(ctrlout), 64'd0);
        chk("rst_dout_en", 64'(dout_en), 64'd0);
        chk("rst_even", 64'(even), 64'd0);
        chk("rst_slip", 64'(slip), 64'd0);
        chk("rst_block_lock", 64'(block_lock), 64'd0);
        rst        = 1'b0;
        nbeats     = 0;
        cur_lock   = 1'b0;
        ctrl_model = 2'b00;
    endtask

    function automatic logic [1:0] vhdr(input int unsigned b);
        return (b % 2 == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] ihdr(input int unsigned b);
        return (b % 2 == 1) ? 2'b11 : 2'b00;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'b01, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        tbl[1] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[2] = '{2'b01, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0};
        tbl[3] = '{2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0};
        tbl[4] = '{2'b01, 32'h8000_0001, 32'h0000_0001, 1'b0};
        tbl[5] = '{2'b10, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0};
        tbl[6] = '{2'b01, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0};
        tbl[7] = '{2'b10, 32'h7FFF_FFFE, 32'h8000_0000, 1'b0};
        tx_s = {$urandom, $urandom};

        rst = 1'b1; data_in_en = 1'b0; half_in = 1'b0; hdr_in = 2'b00; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        idle(2);

        // Acquisition: first 8 blocks from the table, lock exactly on the 64th header.
        for (int i = 0; i < 8; i++)
            blk(tbl[i].hdr, tbl[i].lo, tbl[i].hi, tbl[i].exp_lock, 1'b0);
        for (int unsigned b = 8; b < 64; b++)
            blk_r(vhdr(b), b == 63, 1'b0);

        // Locked window with 15 invalid headers: lock holds.
        for (int unsigned b = 64; b < 128; b++)
            blk_r((b >= 70 && b <= 84) ? ihdr(b) : vhdr(b), 1'b1, 1'b0);

        // Next window: 16th invalid is also the 64th header; loss of lock wins.
        for (int unsigned b = 128; b < 192; b++)
            blk_r((b >= 176) ? ihdr(b) : vhdr(b), b != 191, b == 191);

        // Reset in the middle of the post-slip wait.
        blk_r(2'b11, 1'b0, 1'b0);
        do_reset();
        idle(2);

        // Unlocked slip at block 10; headers in the wait are not tested.
        for (int unsigned b = 0; b < 10; b++)
            blk_r(vhdr(b), 1'b0, 1'b0);
        blk_r(2'b00, 1'b0, 1'b1);
        blk_r(2'b11, 1'b0, 1'b0);
        blk_r(2'b11, 1'b0, 1'b0);
        blk_r(vhdr(13), 1'b0, 1'b0);
        for (int unsigned b = 14; b < 78; b++)
            blk_r(vhdr(b), b == 77, 1'b0);

        // Reset while locked: lock restarts from scratch.
        for (int unsigned b = 0; b < 3; b++)
            blk_r(vhdr(b), 1'b1, 1'b0);
        do_reset();
        idle(2);
        for (int unsigned b = 0; b < 10; b++)
            blk_r(vhdr(b), 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
